// File: rtl/yapp_rx_pkg.sv
// Shared constants, FSM state codes and header field helpers for the YAPP receive router.
package yapp_rx_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_NUM_CH     = 3;
    localparam int DEF_FIFO_DEPTH = 64;
    localparam int MAX_LEN        = 2**(DEF_DATA_W - DEF_ADDR_W) - 1;
    localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_PARITY  = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    // Widths vary per instance, so fields are returned zero-extended to 32 bits.
    function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int unsigned aw);
        return hdr & ((32'd1 << aw) - 32'd1);
    endfunction

    function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int unsigned aw);
        return hdr >> aw;
    endfunction

endpackage

// File: rtl/yapp_commit_fifo.sv
// Per-channel byte FIFO with a commit pointer: readers see only committed bytes,
// and an uncommitted tail can be rewound away.
module yapp_commit_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          commit,
    input  logic                          rewind,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          vld,
    output logic [$clog2(DEPTH):0]        free_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, cm_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic              rd_fire;

    assign vld     = rd_ptr != cm_ptr;
    assign rd_fire = rd_en && vld;
    assign rd_data = vld ? mem[rd_ptr[AW-1:0]] : '0;
    assign wr_nxt  = rewind ? cm_ptr : wr_ptr + PW'(wr_en);
    assign rd_nxt  = rd_ptr + PW'(rd_fire);
    // Space after this cycle's write and pop, so backpressure can be registered.
    assign free_nxt = PW'(DEPTH) - (wr_nxt - rd_nxt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (commit) cm_ptr <= wr_ptr;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/yapp_rx_router.sv
// YAPP input port: parses header/payload/parity, writes packets into per-channel
// commit FIFOs and publishes them only when parity matches.
module yapp_rx_router
    import yapp_rx_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_data_vld,
    output logic                       in_suspend,
    output logic                       error,
    output logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]          ch_vld,
    input  logic [NUM_CH-1:0]          ch_rd,
    output logic [15:0]                drop_cnt
);
    localparam int LEN_W = DATA_W - ADDR_W;
    localparam int PW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);

    logic [1:0]        state, state_d;
    logic [DATA_W-1:0] acc, acc_d;
    logic [LEN_W:0]    rem, rem_d;
    logic [ADDR_W-1:0] tgt, tgt_d, wch;
    logic [31:0]       h_addr, h_len;
    logic              hdr_bad, wr_en, commit, rewind, drop, sus_d;

    logic [NUM_CH-1:0][DATA_W-1:0] rd_data;
    logic [NUM_CH-1:0][PW-1:0]     free_nxt;
    logic [NUM_CH-1:0]             full_nxt;

    assign h_addr  = hdr_addr(32'(in_data), ADDR_W);
    assign h_len   = hdr_len(32'(in_data), ADDR_W);
    assign hdr_bad = (h_addr >= 32'(NUM_CH)) || (h_len == 32'd0);
    assign wch     = (state == ST_IDLE) ? h_addr[ADDR_W-1:0] : tgt;
    assign ch_data = rd_data;

    always_comb begin
        state_d = state;
        acc_d   = acc;
        rem_d   = rem;
        tgt_d   = tgt;
        wr_en   = 1'b0;
        commit  = 1'b0;
        rewind  = 1'b0;
        drop    = 1'b0;
        if (in_data_vld) begin
            case (state)
                ST_IDLE: begin
                    if (hdr_bad) begin
                        // Skip len payload bytes plus the parity byte.
                        drop    = 1'b1;
                        rem_d   = {1'b0, h_len[LEN_W-1:0]} + REM_ONE;
                        state_d = ST_DISCARD;
                    end else begin
                        wr_en   = 1'b1;
                        acc_d   = in_data;
                        rem_d   = {1'b0, h_len[LEN_W-1:0]};
                        tgt_d   = h_addr[ADDR_W-1:0];
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    wr_en = 1'b1;
                    acc_d = acc ^ in_data;
                    rem_d = rem - REM_ONE;
                    if (rem == REM_ONE) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    if (in_data == acc) begin
                        commit = 1'b1;
                    end else begin
                        rewind = 1'b1;
                        drop   = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    rem_d = rem - REM_ONE;
                    if (rem == REM_ONE) state_d = ST_IDLE;
                end
            endcase
        end
    end

    // In IDLE the next header may go anywhere, so any full channel holds the sender.
    always_comb begin
        sus_d = 1'b0;
        if (state_d == ST_PAYLOAD)   sus_d = full_nxt[tgt_d];
        else if (state_d == ST_IDLE) sus_d = |full_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            acc        <= '0;
            rem        <= '0;
            tgt        <= '0;
            in_suspend <= 1'b0;
            error      <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            rem        <= rem_d;
            tgt        <= tgt_d;
            in_suspend <= sus_d;
            error      <= drop;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        yapp_commit_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .wr_en    (wr_en && (wch == ADDR_W'(c))),
            .wr_data  (in_data),
            .commit   (commit && (tgt == ADDR_W'(c))),
            .rewind   (rewind && (tgt == ADDR_W'(c))),
            .rd_en    (ch_rd[c]),
            .rd_data  (rd_data[c]),
            .vld      (ch_vld[c]),
            .free_nxt (free_nxt[c])
        );
        assign full_nxt[c] = (free_nxt[c] == '0);
    end

endmodule

// File: tb/tb_yapp_rx_router.sv
// Directed bench for yapp_rx_router: packet vector table plus backpressure,
// concurrent traffic and mid-packet reset sequences.
module tb_yapp_rx_router;
    localparam int NUM_CH = 3;

    logic                clock = 1'b0;
    logic                reset;
    logic [7:0]          in_data;
    logic                in_data_vld;
    logic                in_suspend;
    logic                error;
    logic [NUM_CH*8-1:0] ch_data;
    logic [NUM_CH-1:0]   ch_vld;
    logic [NUM_CH-1:0]   ch_rd;
    logic [15:0]         drop_cnt;

    always #5 clock = ~clock;

    yapp_rx_router #(.DATA_W(8), .NUM_CH(NUM_CH), .ADDR_W(2), .FIFO_DEPTH(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_data_vld (in_data_vld),
        .in_suspend  (in_suspend),
        .error       (error),
        .ch_data     (ch_data),
        .ch_vld      (ch_vld),
        .ch_rd       (ch_rd),
        .drop_cnt    (drop_cnt)
    );

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [7:0] exp_q [NUM_CH][$];

    always @(negedge clock) if (error === 1'b1) err_pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clock);
        while (in_suspend && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 3000) chk("suspend_timeout", 32'(in_suspend), 0);
        in_data     = b;
        in_data_vld = 1'b1;
        @(posedge clock);
        #1 in_data_vld = 1'b0;
    endtask

    task automatic send_pkt(input int addr, input int len, input logic [7:0] pl[$], input logic [7:0] flip);
        logic [7:0] hdr, par;
        hdr = 8'((len << 2) | addr);
        par = hdr;
        foreach (pl[i]) par ^= pl[i];
        if (addr < NUM_CH && len > 0 && flip == 8'h00) begin
            exp_q[addr].push_back(hdr);
            foreach (pl[i]) exp_q[addr].push_back(pl[i]);
        end
        send_byte(hdr);
        foreach (pl[i]) send_byte(pl[i]);
        send_byte(par ^ flip);
    endtask

    task automatic pop_bytes(input int c, input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clock);
            @(negedge clock);
            while (!ch_vld[c] && t < 3000) begin
                @(negedge clock);
                t++;
            end
            if (!ch_vld[c]) begin
                chk($sformatf("ch%0d_pop_timeout", c), 32'(ch_vld[c]), 1);
                return;
            end
            if (exp_q[c].size() == 0) begin
                chk($sformatf("ch%0d_unexpected_byte", c), 32'(ch_data[c*8 +: 8]), 32'hFFFF_FFFF);
                return;
            end
            chk($sformatf("ch%0d_data", c), 32'(ch_data[c*8 +: 8]), 32'(exp_q[c].pop_front()));
            ch_rd[c] = 1'b1;
            @(posedge clock);
            #1 ch_rd[c] = 1'b0;
        end
    endtask

    typedef struct {
        int         addr;
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] flip;
        int         exp_err;
        logic [2:0] exp_vld;
        int         exp_drop;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic [7:0] pl[$];
        int e0;
        int addrs[9], lens[9], tot[NUM_CH];

        vt[0] = '{1,  4, 8'h11, 8'h11, 8'h00, 0, 3'b010, 0}; // good ch1
        vt[1] = '{1,  4, 8'h11, 8'h11, 8'h01, 1, 3'b000, 1}; // bad parity
        vt[2] = '{3,  5, 8'h70, 8'h01, 8'h00, 1, 3'b000, 2}; // addr out of range
        vt[3] = '{0,  2, 8'hA0, 8'h05, 8'h00, 0, 3'b001, 2}; // good ch0 after discard
        vt[4] = '{2,  0, 8'h00, 8'h00, 8'h00, 1, 3'b000, 3}; // zero length
        vt[5] = '{1,  3, 8'hC3, 8'h3C, 8'h00, 0, 3'b010, 3}; // ch1 after rewind
        vt[6] = '{2, 40, 8'h01, 8'h03, 8'h00, 0, 3'b100, 3}; // long ch2

        reset = 1'b0; in_data = '0; in_data_vld = 1'b0; ch_rd = '0;
        repeat (3) @(negedge clock);
        chk("rst_vld", 32'(ch_vld), 0);
        chk("rst_data", 32'(ch_data), 0);
        chk("rst_suspend", 32'(in_suspend), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            pl = {};
            for (int j = 0; j < vt[i].len; j++) pl.push_back(8'(vt[i].base + j * vt[i].step));
            e0 = err_pulses;
            send_pkt(vt[i].addr, vt[i].len, pl, vt[i].flip);
            chk($sformatf("v%0d_vld_after_parity", i), 32'(ch_vld), 32'(vt[i].exp_vld));
            repeat (2) @(negedge clock);
            chk($sformatf("v%0d_err_pulses", i), 32'(err_pulses - e0), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_drop_cnt", i), 32'(drop_cnt), 32'(vt[i].exp_drop));
            chk($sformatf("v%0d_suspend", i), 32'(in_suspend), 0);
            for (int c = 0; c < NUM_CH; c++)
                if (vt[i].exp_vld[c]) pop_bytes(c, exp_q[c].size(), 0);
            chk($sformatf("v%0d_drained", i), 32'(ch_vld), 0);
        end

        // Fill ch0 completely, then refill while a slow reader drains.
        pl = {};
        for (int j = 0; j < 63; j++) pl.push_back(8'(j + 1));
        send_pkt(0, 63, pl, 8'h00);
        chk("full_suspend", 32'(in_suspend), 1);
        chk("full_vld", 32'(ch_vld), 32'b001);
        pl = {};
        for (int j = 0; j < 10; j++) pl.push_back(8'(8'h80 + j));
        fork
            send_pkt(0, 10, pl, 8'h00);
            pop_bytes(0, 75, 3);
        join
        repeat (2) @(negedge clock);
        chk("full_drained_vld", 32'(ch_vld), 0);
        chk("full_queue_empty", 32'(exp_q[0].size()), 0);

        // Back-to-back traffic on all channels with concurrent random reads.
        tot = '{0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            addrs[i] = i % NUM_CH;
            lens[i]  = $urandom_range(20, 1);
            tot[addrs[i]] += lens[i] + 1;
        end
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    logic [7:0] rp[$];
                    rp = {};
                    for (int j = 0; j < lens[i]; j++) rp.push_back(8'($urandom));
                    send_pkt(addrs[i], lens[i], rp, 8'h00);
                end
            end
            pop_bytes(0, tot[0], 2);
            pop_bytes(1, tot[1], 2);
            pop_bytes(2, tot[2], 2);
        join
        repeat (2) @(negedge clock);
        chk("mix_vld", 32'(ch_vld), 0);
        chk("mix_queues", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 0);
        chk("mix_drop", 32'(drop_cnt), 3);

        // Reset in the middle of a ch2 payload with a committed ch0 packet pending.
        pl = {};
        pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
        send_pkt(0, 3, pl, 8'h00);
        chk("pre_reset_vld", 32'(ch_vld), 32'b001);
        send_byte(8'h16);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(ch_vld), 0);
        chk("mid_rst_data", 32'(ch_data), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        chk("mid_rst_suspend", 32'(in_suspend), 0);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < NUM_CH; c++) exp_q[c] = {};
        pl = {};
        pl.push_back(8'h5A); pl.push_back(8'hA5);
        send_pkt(2, 2, pl, 8'h00);
        chk("post_rst_vld", 32'(ch_vld), 32'b100);
        pop_bytes(2, 3, 0);
        repeat (2) @(negedge clock);
        chk("post_rst_drained", 32'(ch_vld), 0);
        chk("post_rst_drop", 32'(drop_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
